// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage next-PC sequencer: FSM states, redirect
// sources (ordered so a numeric compare gives priority) and the pending record.
package pc_seq_pkg;

    localparam int PCSEQ_XLEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pcseq_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } redirect_src_e;

    typedef struct packed {
        redirect_src_e           src;
        logic [PCSEQ_XLEN-1:0]   target;
    } redirect_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect register: a strictly higher-priority source
// overwrites the entry, i_clr empties it. Only the source field is reset.
module pc_redirect_buf
    import pc_seq_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_clr,
    input  redirect_t i_new,
    output redirect_t o_pend
);

    redirect_src_e           r_src;
    logic [PCSEQ_XLEN-1:0]   r_target;
    logic                    w_take;

    assign w_take = !i_clr && (i_new.src > r_src);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src <= SRC_NONE;
        end else if (i_clr) begin
            r_src <= SRC_NONE;
        end else if (w_take) begin
            r_src <= i_new.src;
        end
    end

    // Target is qualified by r_src, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_target <= i_new.target;
        end
    end

    always_comb begin
        o_pend        = '0;
        o_pend.src    = r_src;
        o_pend.target = r_target;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage. Optional feature macro:
// PCSEQ_MISALIGN_TRAP_EN (misaligned redirect targets become a trap).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = PCSEQ_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            imem_ready_i,
    input  logic            jmp_valid_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    output logic            pc_sel_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            misalign_o
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);

    pcseq_state_e   r_state, w_state_nxt;
    logic [BW-1:0]  r_boot_cnt, w_boot_cnt_nxt;
    logic           w_blocked;
    logic           w_advance;
    redirect_t      w_raw, w_new, w_pend, w_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_boot_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_blocked      = stall_i | !imem_ready_i;
        case (r_state)
            BOOT: begin
                if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) begin
                    w_state_nxt = w_blocked ? HOLD : RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + 1'b1;
                end
            end
            RUN, HOLD: w_state_nxt = w_blocked ? HOLD : RUN;
            default:   w_state_nxt = BOOT;
        endcase
    end

    // This cycle's new request, highest priority source first.
    always_comb begin
        w_raw = '0;
        if (trap_i) begin
            w_raw.src    = SRC_TRAP;
            w_raw.target = TRAP_VECTOR;
        end else if (br_taken_i) begin
            w_raw.src    = SRC_BR;
            w_raw.target = br_target_i;
        end else if (jmp_valid_i) begin
            w_raw.src    = SRC_JMP;
            w_raw.target = jmp_target_i;
        end
    end

`ifdef PCSEQ_MISALIGN_TRAP_EN
    always_comb begin
        w_new      = w_raw;
        misalign_o = (w_raw.src != SRC_NONE) && (w_raw.target[1:0] != 2'b00);
        if (misalign_o) begin
            w_new.src    = SRC_TRAP;
            w_new.target = TRAP_VECTOR;
        end
    end
`else
    always_comb begin
        w_new              = w_raw;
        w_new.target[1:0]  = 2'b00;
        misalign_o         = 1'b0;
    end
`endif

    pc_redirect_buf u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_advance),
        .i_new  (w_new),
        .o_pend (w_pend)
    );

    // A fresh request outranks anything already pending.
    always_comb begin
        w_advance   = (r_state != BOOT) && !stall_i && imem_ready_i;
        w_win       = (w_new.src != SRC_NONE) ? w_new : w_pend;
        pc_en_o     = w_advance;
        pc_sel_o    = w_advance && (w_win.src != SRC_NONE);
        jump_addr_o = (w_win.src != SRC_NONE) ? w_win.target : RESET_VECTOR;
        flush_if_o  = (w_new.src != SRC_NONE);
        flush_id_o  = (w_new.src >= SRC_BR);
        imem_req_o  = (r_state != BOOT);
        imem_addr_o = pc_i;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer, with a behavioural PC register.
// Misalign expectations follow PCSEQ_MISALIGN_TRAP_EN.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall_i, imem_ready_i, jmp_valid_i, br_taken_i, trap_i;
    logic [31:0] jmp_target_i, br_target_i, pc_i;
    logic        pc_en_o, pc_sel_o, imem_req_o, flush_if_o, flush_id_o, misalign_o;
    logic [31:0] jump_addr_o, imem_addr_o;

    int tests;
    int fails;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .imem_ready_i (imem_ready_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_target_i (jmp_target_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .trap_i       (trap_i),
        .pc_i         (pc_i),
        .pc_en_o      (pc_en_o),
        .pc_sel_o     (pc_sel_o),
        .jump_addr_o  (jump_addr_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .flush_if_o   (flush_if_o),
        .flush_id_o   (flush_id_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register the sequencer steers.
    always @(posedge clk or negedge reset) begin
        if (!reset)       pc_i <= 32'h0;
        else if (pc_en_o) pc_i <= pc_sel_o ? jump_addr_o : pc_i + 32'd4;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; stall_i = 0; imem_ready_i = 1; jmp_valid_i = 0; br_taken_i = 0; trap_i = 0;
        jmp_target_i = 0; br_target_i = 0;
        repeat (3) tick();
        tests++; if (pc_en_o !== 1'b0) begin fails++; $display("FAIL rst_pc_en got %0h want 0", pc_en_o); end
        tests++; if (pc_sel_o !== 1'b0) begin fails++; $display("FAIL rst_pc_sel got %0h want 0", pc_sel_o); end
        tests++; if (jump_addr_o !== 32'h0) begin fails++; $display("FAIL rst_jump_addr got %0h want 0", jump_addr_o); end
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL rst_imem_req got %0h want 0", imem_req_o); end
        tests++; if (flush_if_o !== 1'b0 || flush_id_o !== 1'b0) begin fails++; $display("FAIL rst_flush got %0h/%0h want 0/0", flush_if_o, flush_id_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL rst_misalign got %0h want 0", misalign_o); end
        reset = 1'b1;
        #1;
        tests++; if (pc_en_o !== 1'b0 || imem_req_o !== 1'b0) begin fails++; $display("FAIL boot0 pc_en/req got %0h/%0h want 0/0", pc_en_o, imem_req_o); end
        tick();
        tests++; if (pc_en_o !== 1'b0) begin fails++; $display("FAIL boot1 pc_en got %0h want 0", pc_en_o); end
        tick();
        tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== 1'b0 || imem_req_o !== 1'b1) begin fails++; $display("FAIL run0 en/sel/req got %0h/%0h/%0h want 1/0/1", pc_en_o, pc_sel_o, imem_req_o); end
        tests++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL run0 addr got %0h want 0", imem_addr_o); end
        tick();
        tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== 1'b0 || imem_addr_o !== 32'h4) begin fails++; $display("FAIL run1 en/sel/addr got %0h/%0h/%0h want 1/0/4", pc_en_o, pc_sel_o, imem_addr_o); end
        tick();
        tests++; if (imem_addr_o !== 32'h8) begin fails++; $display("FAIL run2 addr got %0h want 8", imem_addr_o); end
    endtask

    task automatic test_branch;
        br_taken_i = 1; br_target_i = 32'h40;
        #1;
        tests++; if (flush_if_o !== 1'b1 || flush_id_o !== 1'b1) begin fails++; $display("FAIL br_flush got %0h/%0h want 1/1", flush_if_o, flush_id_o); end
        tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== 1'b1) begin fails++; $display("FAIL br_en_sel got %0h/%0h want 1/1", pc_en_o, pc_sel_o); end
        tests++; if (jump_addr_o !== 32'h40) begin fails++; $display("FAIL br_addr got %0h want 40", jump_addr_o); end
        tick();
        br_taken_i = 0;
        #1;
        tests++; if (imem_addr_o !== 32'h40 || flush_if_o !== 1'b0 || pc_sel_o !== 1'b0) begin fails++; $display("FAIL br_after addr/fif/sel got %0h/%0h/%0h want 40/0/0", imem_addr_o, flush_if_o, pc_sel_o); end
        tick();
    endtask

    task automatic test_stall_pending;
        // pc is 0x44 here
        stall_i = 1; jmp_valid_i = 1; jmp_target_i = 32'h80;
        #1;
        tests++; if (pc_en_o !== 1'b0 || flush_if_o !== 1'b1 || flush_id_o !== 1'b0) begin fails++; $display("FAIL st_jmp en/fif/fid got %0h/%0h/%0h want 0/1/0", pc_en_o, flush_if_o, flush_id_o); end
        tick();
        jmp_valid_i = 0; br_taken_i = 1; br_target_i = 32'h20;
        #1;
        tests++; if (pc_en_o !== 1'b0 || flush_id_o !== 1'b1) begin fails++; $display("FAIL st_br en/fid got %0h/%0h want 0/1", pc_en_o, flush_id_o); end
        tick();
        br_taken_i = 0;
        #1;
        tests++; if (pc_en_o !== 1'b0 || jump_addr_o !== 32'h20 || imem_addr_o !== 32'h44) begin fails++; $display("FAIL st_hold en/addr/pc got %0h/%0h/%0h want 0/20/44", pc_en_o, jump_addr_o, imem_addr_o); end
        tick();
        stall_i = 0;
        #1;
        tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== 1'b1 || jump_addr_o !== 32'h20) begin fails++; $display("FAIL st_rel en/sel/addr got %0h/%0h/%0h want 1/1/20", pc_en_o, pc_sel_o, jump_addr_o); end
        tick();
        tests++; if (imem_addr_o !== 32'h20 || pc_sel_o !== 1'b0) begin fails++; $display("FAIL st_after addr/sel got %0h/%0h want 20/0", imem_addr_o, pc_sel_o); end
        tick();
    endtask

    task automatic test_equal_drop;
        stall_i = 1; br_taken_i = 1; br_target_i = 32'h30;
        tick();
        br_target_i = 32'h50;
        #1;
        tests++; if (flush_id_o !== 1'b1 || pc_en_o !== 1'b0) begin fails++; $display("FAIL eq_br2 fid/en got %0h/%0h want 1/0", flush_id_o, pc_en_o); end
        tick();
        br_taken_i = 0; jmp_valid_i = 1; jmp_target_i = 32'h70;
        tick();
        jmp_valid_i = 0; stall_i = 0;
        #1;
        tests++; if (pc_sel_o !== 1'b1 || jump_addr_o !== 32'h30) begin fails++; $display("FAIL eq_rel sel/addr got %0h/%0h want 1/30", pc_sel_o, jump_addr_o); end
        tick();
        tests++; if (imem_addr_o !== 32'h30) begin fails++; $display("FAIL eq_after addr got %0h want 30", imem_addr_o); end
        tick();
    endtask

    task automatic test_priority;
        trap_i = 1; br_taken_i = 1; br_target_i = 32'h40; jmp_valid_i = 1; jmp_target_i = 32'h80;
        #1;
        tests++; if (jump_addr_o !== 32'h100 || pc_sel_o !== 1'b1) begin fails++; $display("FAIL pri addr/sel got %0h/%0h want 100/1", jump_addr_o, pc_sel_o); end
        tests++; if (flush_if_o !== 1'b1 || flush_id_o !== 1'b1) begin fails++; $display("FAIL pri_flush got %0h/%0h want 1/1", flush_if_o, flush_id_o); end
        tick();
        trap_i = 0; br_taken_i = 0; jmp_valid_i = 0;
        #1;
        tests++; if (flush_if_o !== 1'b0 || flush_id_o !== 1'b0 || imem_addr_o !== 32'h100) begin fails++; $display("FAIL pri_after fif/fid/addr got %0h/%0h/%0h want 0/0/100", flush_if_o, flush_id_o, imem_addr_o); end
        tick();
    endtask

    task automatic test_reset_discard;
        imem_ready_i = 0; br_taken_i = 1; br_target_i = 32'h60;
        #1;
        tests++; if (pc_en_o !== 1'b0 || imem_req_o !== 1'b1) begin fails++; $display("FAIL rd_cap en/req got %0h/%0h want 0/1", pc_en_o, imem_req_o); end
        tick();
        br_taken_i = 0;
        tick();
        reset = 1'b0;
        #1;
        tests++; if (imem_req_o !== 1'b0 || pc_sel_o !== 1'b0) begin fails++; $display("FAIL rd_rst req/sel got %0h/%0h want 0/0", imem_req_o, pc_sel_o); end
        tick();
        tick();
        reset = 1'b1; imem_ready_i = 1;
        #1;
        tests++; if (pc_en_o !== 1'b0) begin fails++; $display("FAIL rd_boot0 en got %0h want 0", pc_en_o); end
        tick();
        tick();
        tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== 1'b0 || jump_addr_o !== 32'h0) begin fails++; $display("FAIL rd_run en/sel/addr got %0h/%0h/%0h want 1/0/0", pc_en_o, pc_sel_o, jump_addr_o); end
        tick();
        tests++; if (pc_sel_o !== 1'b0 || imem_addr_o !== 32'h4) begin fails++; $display("FAIL rd_seq sel/addr got %0h/%0h want 0/4", pc_sel_o, imem_addr_o); end
        tick();
    endtask

    task automatic test_misalign;
        logic exp_mis;
`ifdef PCSEQ_MISALIGN_TRAP_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        jmp_valid_i = 1; jmp_target_i = 32'h102;
        #1;
        tests++; if (jump_addr_o !== 32'h100 || pc_sel_o !== 1'b1) begin fails++; $display("FAIL mis addr/sel got %0h/%0h want 100/1", jump_addr_o, pc_sel_o); end
        tests++; if (misalign_o !== exp_mis || flush_id_o !== exp_mis) begin fails++; $display("FAIL mis_flag mis/fid got %0h/%0h want %0h/%0h", misalign_o, flush_id_o, exp_mis, exp_mis); end
        tests++; if (flush_if_o !== 1'b1) begin fails++; $display("FAIL mis_fif got %0h want 1", flush_if_o); end
        tick();
        jmp_valid_i = 0;
        #1;
        tests++; if (misalign_o !== 1'b0 || imem_addr_o !== 32'h100) begin fails++; $display("FAIL mis_after mis/addr got %0h/%0h want 0/100", misalign_o, imem_addr_o); end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_branch();
        test_stall_pending();
        test_equal_drop();
        test_priority();
        test_reset_discard();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
